// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM wrapper: sliced RAM, post-reset clear sweep, read hold, init-access flag.
// Optional macro SPSRAM_OUTREG_EN adds a Q output register (read latency 2 instead of 1).
module ct_f_spsram_param #(
  parameter int   ADDR_WIDTH  = 10,
  parameter int   DATA_WIDTH  = 92,
  parameter int   SLICE_WIDTH = 23,
  parameter logic INIT_VALUE  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_DONE,
  output logic                  INIT_VIOL
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int SLICE_NUM = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

  if (SLICE_WIDTH < 1 || SLICE_WIDTH > DATA_WIDTH) begin : g_bad_slice
    $error("ct_f_spsram_param: SLICE_WIDTH must be in 1..DATA_WIDTH");
  end

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_init_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr_hold;
  logic                    r_init_done;
  logic                    r_init_viol;
  logic                    r_mask;
  logic                    w_init;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_init_word;
  logic [DATA_WIDTH-1:0]   w_ram_dout;
  logic [DATA_WIDTH-1:0]   w_q_masked;
  logic                    w_unused_wen;

  assign w_init      = (r_state == S_INIT);
  assign w_last      = w_init && (r_init_cnt == {ADDR_WIDTH{1'b1}});
  assign w_init_word = {DATA_WIDTH{INIT_VALUE}};
  assign w_unused_wen = ^WEN;

  // With CEN high the held address keeps being read, which is what holds Q.
  assign w_addr = w_init ? r_init_cnt : (CEN ? r_addr_hold : A);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (w_last) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) r_state <= S_INIT;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_init_cnt  <= '0;
      r_addr_hold <= '0;
      r_init_done <= 1'b0;
      r_init_viol <= 1'b0;
      r_mask      <= 1'b0;
    end else begin
      if (w_init) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_last) r_init_done <= 1'b1;
      if (!CEN && !r_init_done) r_init_viol <= 1'b1;
      if (!w_init && !CEN) r_addr_hold <= A;
      // Mask opens together with the first post-sweep RAM read data.
      r_mask <= r_init_done;
    end
  end

  for (genvar k = 0; k < SLICE_NUM; k++) begin : g_slice
    localparam int LSB = k * SLICE_WIDTH;
    localparam int MSB = ((k + 1) * SLICE_WIDTH > DATA_WIDTH) ? DATA_WIDTH - 1
                                                              : (k + 1) * SLICE_WIDTH - 1;
    localparam int SW  = MSB - LSB + 1;

    logic [SW-1:0] r_mem [DEPTH];
    logic [SW-1:0] r_dout;
    logic [SW-1:0] w_din;
    logic          w_we;

    assign w_we  = w_init ? 1'b1 : (!CEN && !GWEN && !WEN[MSB]);
    assign w_din = w_init ? w_init_word[MSB:LSB] : D[MSB:LSB];

    always_ff @(posedge CLK) begin
      if (w_we) r_mem[w_addr] <= w_din;
      r_dout <= r_mem[w_addr];
    end

    assign w_ram_dout[MSB:LSB] = r_dout;
  end

  assign w_q_masked = w_ram_dout & {DATA_WIDTH{r_mask}};

`ifdef SPSRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) r_q <= '0;
    else           r_q <= w_q_masked;
  end

  assign Q = r_q;
`else
  assign Q = w_q_masked;
`endif

  assign INIT_DONE = r_init_done;
  assign INIT_VIOL = r_init_viol;

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Directed bench for ct_f_spsram_param: clear sweep timing, reads/writes, slice enables, hold, INIT_VIOL, reset.
module tb_ct_f_spsram_param;

  localparam int AW = 10;
  localparam int DW = 92;
`ifdef SPSRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          cpurst_b;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          INIT_DONE;
  logic          INIT_VIOL;

  int n_cmp = 0;
  int n_mis = 0;

  ct_f_spsram_param #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SLICE_WIDTH(23),
    .INIT_VALUE (1'b0)
  ) u_dut (
    .CLK      (CLK),
    .cpurst_b (cpurst_b),
    .A        (A),
    .CEN      (CEN),
    .GWEN     (GWEN),
    .WEN      (WEN),
    .D        (D),
    .Q        (Q),
    .INIT_DONE(INIT_DONE),
    .INIT_VIOL(INIT_VIOL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] wen);
    A = addr; D = data; WEN = wen; CEN = 1'b0; GWEN = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    A = addr; CEN = 1'b0; GWEN = 1'b1; WEN = '1;
    tick();
    CEN = 1'b1;
    repeat (LAT - 1) tick();
    check(tag, Q, exp);
  endtask

  // Runs the clear sweep; optionally pulses CEN low once, or stops early to allow a mid-sweep reset.
  task automatic run_sweep(input int viol_at, input int abort_at, output int cyc, output bit qnz);
    cyc = 0;
    qnz = 1'b0;
    while (!INIT_DONE && cyc < 2000 && cyc != abort_at) begin
      if (cyc == viol_at) begin
        A = 10'd5; D = '1; WEN = '0; GWEN = 1'b0; CEN = 1'b0;
      end else begin
        idle_inputs();
      end
      tick();
      cyc++;
      if (Q != '0) qnz = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic apply_reset();
    cpurst_b = 1'b0;
    tick();
    tick();
    cpurst_b = 1'b1;
  endtask

  logic [DW-1:0] pat;
  logic [DW-1:0] exp_v;
  int            cyc;
  bit            qnz;
  bit            hold_bad;

  initial begin
    idle_inputs();
    A = '0;
    cpurst_b = 1'b0;
    #2;
    check("rst_q", Q, '0);
    check("rst_done", DW'(INIT_DONE), '0);
    check("rst_viol", DW'(INIT_VIOL), '0);
    tick();
    tick();
    cpurst_b = 1'b1;

    run_sweep(-1, -1, cyc, qnz);
    check("sweep_len", DW'(cyc), DW'(1024));
    check("sweep_q_zero", DW'(qnz), '0);
    check("sweep_no_viol", DW'(INIT_VIOL), '0);

    rd("rd_3ff_cleared", 10'h3FF, '0);
    rd("rd_5_cleared", 10'd5, '0);

    wr(10'd5, '1, '0);
    rd("rd_5_ones", 10'd5, {DW{1'b1}});

    exp_v = '0;
    exp_v[45:23] = '1;
    pat = '1;
    pat[45] = 1'b0;
    wr(10'd7, '1, pat);
    rd("rd_7_slice1", 10'd7, exp_v);

    pat = '1;
    pat[30] = 1'b0;
    wr(10'd8, '1, pat);
    rd("rd_8_nonmsb_wen", 10'd8, '0);

    pat = 92'h123_4567_89AB_CDEF_0123_456;
    wr(10'd9, pat, '0);
    rd("rd_9_pattern", 10'd9, pat);

    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      A = AW'(i * 37 + 1);
      tick();
      if (Q !== pat) hold_bad = 1'b1;
    end
    check("hold_cen_high", DW'(hold_bad), '0);
    check("hold_final_q", Q, pat);

    exp_v = pat;
    exp_v[91:69] = '0;
    wr(10'd9, '0, ~(92'b1 << 91));
    rd("rd_9_last_slice", 10'd9, exp_v);
    rd("rd_5_still_ones", 10'd5, {DW{1'b1}});
    rd("rd_7_still", 10'd7, 92'h0000000_00003FFF_FF800000);

    apply_reset();
    check("rst2_q", Q, '0);
    check("rst2_done", DW'(INIT_DONE), '0);
    run_sweep(100, -1, cyc, qnz);
    check("sweep2_len", DW'(cyc), DW'(1024));
    check("sweep2_q_zero", DW'(qnz), '0);
    check("viol_sticky", DW'(INIT_VIOL), DW'(1));
    rd("rd_5_cleared2", 10'd5, '0);
    rd("rd_9_cleared2", 10'd9, '0);
    check("viol_after_reads", DW'(INIT_VIOL), DW'(1));

    apply_reset();
    run_sweep(100, 500, cyc, qnz);
    check("viol_mid_sweep", DW'(INIT_VIOL), DW'(1));
    check("done_mid_sweep", DW'(INIT_DONE), '0);
    cpurst_b = 1'b0;
    #1;
    check("viol_cleared", DW'(INIT_VIOL), '0);
    tick();
    tick();
    cpurst_b = 1'b1;
    run_sweep(-1, -1, cyc, qnz);
    check("sweep3_len", DW'(cyc), DW'(1024));
    check("sweep3_no_viol", DW'(INIT_VIOL), '0);
    rd("rd_0_after_restart", 10'd0, '0);
    wr(10'h3FF, pat, '0);
    rd("rd_3ff_pattern", 10'h3FF, pat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
